gbar_responder: RTL



---
 rtl/gbar_responder_pkg.sv | 20 ++
 rtl/gbar_responder_if.sv | 25 ++
 rtl/gbar_rr_arbiter.sv | 48 ++++
 rtl/gbar_responder.sv | 147 ++++++++++++++
 4 files changed

// File: rtl/gbar_responder_pkg.sv
// Shared widths and request/response payload types for the global-barrier responder.
package gbar_responder_pkg;

  localparam int unsigned NUM_CORES     = 4;
  localparam int unsigned NUM_BARRIERS  = 8;
  localparam int unsigned NC_WIDTH      = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;
  localparam int unsigned NB_WIDTH      = (NUM_BARRIERS > 1) ? $clog2(NUM_BARRIERS) : 1;
  localparam int unsigned PERF_CTR_BITS = 16;

  typedef struct packed {
    logic [NB_WIDTH-1:0] id;
    logic [NC_WIDTH-1:0] size_m1;
    logic [NC_WIDTH-1:0] core_id;
  } gbar_req_data_t;

  typedef struct packed {
    logic [NB_WIDTH-1:0] id;
  } gbar_rsp_data_t;

endpackage

// File: rtl/gbar_responder_if.sv
// Core-side gbar request channel plus the broadcast release response.
interface gbar_responder_if #(
  parameter int unsigned NUM_REQS = 4
);
  import gbar_responder_pkg::*;

  logic [NUM_REQS-1:0]          req_valid;
  logic [NUM_REQS*NB_WIDTH-1:0] req_id;
  logic [NUM_REQS*NC_WIDTH-1:0] req_size_m1;
  logic [NUM_REQS*NC_WIDTH-1:0] req_core_id;
  logic [NUM_REQS-1:0]          req_ready;
  logic                         rsp_valid;
  logic [NB_WIDTH-1:0]          rsp_id;

  modport master (
    output req_valid, req_id, req_size_m1, req_core_id,
    input  req_ready, rsp_valid, rsp_id
  );

  modport slave (
    input  req_valid, req_id, req_size_m1, req_core_id,
    output req_ready, rsp_valid, rsp_id
  );

endinterface

// File: rtl/gbar_rr_arbiter.sv
// Round-robin arbiter: one grant per cycle, search starts at the pointer, pointer moves
// past the winner. No grants while reset is asserted.
module gbar_rr_arbiter #(
  parameter int unsigned N = 4,
  localparam int unsigned IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [N-1:0]  valid_in,
  output logic [IW-1:0] grant_index,
  output logic [N-1:0]  grant_onehot,
  output logic          grant_valid
);

  logic [IW-1:0] ptr_q, ptr_d;
  logic [N-1:0]  req;

  assign req = reset ? '0 : valid_in;

  always_comb begin
    grant_valid  = 1'b0;
    grant_index  = '0;
    grant_onehot = '0;
    for (int unsigned i = 0; i < N; i++) begin
      if (!grant_valid && req[(32'(ptr_q) + i) % N]) begin
        grant_valid  = 1'b1;
        grant_index  = IW'((32'(ptr_q) + i) % N);
        grant_onehot[(32'(ptr_q) + i) % N] = 1'b1;
      end
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (grant_valid) begin
      ptr_d = IW'((32'(grant_index) + 32'd1) % N);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/gbar_responder.sv
// Global-barrier responder: tracks arrived cores per barrier id and broadcasts a one-cycle
// registered release. Define GBAR_PERF_EN to add release/stall performance counters.
module gbar_responder
  import gbar_responder_pkg::*;
#(
  parameter int unsigned NUM_REQS = 4,
  localparam int unsigned RW = (NUM_REQS > 1) ? $clog2(NUM_REQS) : 1
) (
  input  logic                     clk,
  input  logic                     reset,
  gbar_responder_if.slave          bus,
  output logic                     busy
`ifdef GBAR_PERF_EN
  ,
  output logic [PERF_CTR_BITS-1:0] perf_releases,
  output logic [PERF_CTR_BITS-1:0] perf_stalls
`endif
);

  gbar_req_data_t      reqs [NUM_REQS];
  gbar_req_data_t      acc;
  logic [RW-1:0]       grant_index;
  logic [NUM_REQS-1:0] grant_onehot;
  logic                grant_valid;

  logic [NUM_CORES-1:0] mask_q [NUM_BARRIERS];
  logic [NUM_CORES-1:0] mask_d [NUM_BARRIERS];
  logic [NC_WIDTH-1:0]  ctr_q  [NUM_BARRIERS];
  logic [NC_WIDTH-1:0]  ctr_d  [NUM_BARRIERS];
  logic [NC_WIDTH-1:0]  size_q [NUM_BARRIERS];
  logic                 rsp_valid_q, rsp_valid_d;
  logic [NB_WIDTH-1:0]  rsp_id_q, rsp_id_d;
  logic                 busy_q, busy_d;
  logic                 dup_hit;

  for (genvar p = 0; p < NUM_REQS; p++) begin : g_unpack
    assign reqs[p].id      = bus.req_id[p*NB_WIDTH +: NB_WIDTH];
    assign reqs[p].size_m1 = bus.req_size_m1[p*NC_WIDTH +: NC_WIDTH];
    assign reqs[p].core_id = bus.req_core_id[p*NC_WIDTH +: NC_WIDTH];
  end

  gbar_rr_arbiter #(
    .N (NUM_REQS)
  ) u_arb (
    .clk          (clk),
    .reset        (reset),
    .valid_in     (bus.req_valid),
    .grant_index  (grant_index),
    .grant_onehot (grant_onehot),
    .grant_valid  (grant_valid)
  );

  assign acc           = reqs[grant_index];
  assign bus.req_ready = grant_onehot;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_id    = rsp_id_q;
  assign busy          = busy_q;

  // A duplicate arrival is dropped; a release clears the epoch instead of setting the bit.
  always_comb begin
    mask_d      = mask_q;
    ctr_d       = ctr_q;
    rsp_valid_d = 1'b0;
    rsp_id_d    = rsp_id_q;
    dup_hit     = 1'b0;
    if (grant_valid) begin
      dup_hit = mask_q[acc.id][acc.core_id];
      if (!dup_hit) begin
        if (ctr_q[acc.id] == acc.size_m1) begin
          mask_d[acc.id] = '0;
          ctr_d[acc.id]  = '0;
          rsp_valid_d    = 1'b1;
          rsp_id_d       = acc.id;
        end else begin
          mask_d[acc.id][acc.core_id] = 1'b1;
          ctr_d[acc.id]               = ctr_q[acc.id] + NC_WIDTH'(1);
        end
      end
    end
  end

  always_comb begin
    busy_d = 1'b0;
    for (int unsigned b = 0; b < NUM_BARRIERS; b++) begin
      busy_d = busy_d | (|mask_q[b]);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned b = 0; b < NUM_BARRIERS; b++) begin
        mask_q[b] <= '0;
        ctr_q[b]  <= '0;
        size_q[b] <= '0;
      end
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= '0;
      busy_q      <= 1'b0;
    end else begin
      mask_q      <= mask_d;
      ctr_q       <= ctr_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_id_q    <= rsp_id_d;
      busy_q      <= busy_d;
      if (grant_valid && !dup_hit) begin
        size_q[acc.id] <= acc.size_m1;
      end
    end
  end

  // Protocol checks only; they warn and let simulation continue.
  always_ff @(posedge clk) begin
    if (!reset && grant_valid) begin
      assert (!dup_hit)
        else $warning("gbar: duplicate arrival core %0d barrier %0d", acc.core_id, acc.id);
      assert (dup_hit || mask_q[acc.id] == '0 || size_q[acc.id] == acc.size_m1)
        else $warning("gbar: size_m1 differs from earlier arrival on barrier %0d", acc.id);
    end
  end

`ifdef GBAR_PERF_EN
  logic [PERF_CTR_BITS-1:0] rel_cnt_q, stall_cnt_q, stall_inc;

  always_comb begin
    stall_inc = '0;
    for (int unsigned p = 0; p < NUM_REQS; p++) begin
      if (bus.req_valid[p] && !grant_onehot[p]) begin
        stall_inc = stall_inc + PERF_CTR_BITS'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rel_cnt_q   <= '0;
      stall_cnt_q <= '0;
    end else begin
      rel_cnt_q   <= rel_cnt_q + PERF_CTR_BITS'(rsp_valid_q);
      stall_cnt_q <= stall_cnt_q + stall_inc;
    end
  end

  assign perf_releases = rel_cnt_q;
  assign perf_stalls   = stall_cnt_q;
`endif

endmodule
